// File: rtl/array_ops_pkg.sv
// array_ops_pkg: shared index-width helper and serializer FSM states for the array datapath.
package array_ops_pkg;
  typedef enum logic {IDLE, STREAM} ser_state_t;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/convert_3d_to_1d_array.sv
// convert_3d_to_1d_array: flattens a [ROWS][COLS] element array row-major, element [0][0] in the low bits.
module convert_3d_to_1d_array #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic [BIT_WIDTH-1:0]           in [ROWS][COLS],
  output logic [ROWS*COLS*BIT_WIDTH-1:0] out
);
  for (genvar r = 0; r < ROWS; r++) begin : g_r
    for (genvar c = 0; c < COLS; c++) begin : g_c
      assign out[(r*COLS+c)*BIT_WIDTH +: BIT_WIDTH] = in[r][c];
    end
  end
endmodule

// File: rtl/serialize_3d_array.sv
// serialize_3d_array: captures a whole array on a handshake and streams it row-major, one element per beat.
module serialize_3d_array
  import array_ops_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int ROW_W = idx_width(ROWS),
  localparam int COL_W = idx_width(COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in [ROWS][COLS],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic [ROW_W-1:0]     out_row,
  output logic [COL_W-1:0]     out_col,
  output logic                 out_last_col,
  output logic                 out_last
);
  localparam int FLAT_W = ROWS*COLS*BIT_WIDTH;
  localparam int IDX_W = idx_width(FLAT_W);
  ser_state_t r_state, w_next;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [FLAT_W-1:0] r_hold, w_flat;
  logic [IDX_W-1:0] w_base;
  logic w_in_hs, w_out_hs;

  convert_3d_to_1d_array #(.BIT_WIDTH(BIT_WIDTH), .ROWS(ROWS), .COLS(COLS)) u_flat (
    .in (in),
    .out(w_flat)
  );

  assign w_in_hs = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;

  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  // The last-beat handshake behaves like IDLE: a waiting array is taken with no bubble.
  always_comb
    w_next = (r_state == IDLE || (w_out_hs && out_last)) ? (w_in_hs ? STREAM : IDLE) : r_state;

  always_comb begin
    out_valid = r_state == STREAM;
    out_last_col = r_col == COL_W'(COLS-1);
    out_last = out_last_col && r_row == ROW_W'(ROWS-1);
    in_ready = r_state == IDLE || (out_valid && out_last && out_ready);
    out_row = r_row;
    out_col = r_col;
    w_base = IDX_W'((int'(r_row)*COLS + int'(r_col))*BIT_WIDTH);
    out_data = r_hold[w_base +: BIT_WIDTH];
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_out_hs) begin
      r_col <= out_last_col ? '0 : r_col + COL_W'(1);
      r_row <= out_last ? '0 : (out_last_col ? r_row + ROW_W'(1) : r_row);
    end else if (w_in_hs) begin
      r_row <= '0;
      r_col <= '0;
    end

  // Holding register has no reset; out_data is only meaningful with out_valid.
  always_ff @(posedge clk)
    if (rst_n && w_in_hs) r_hold <= w_flat;
endmodule

// File: tb/tb_serialize_3d_array.sv
// tb_serialize_3d_array: scoreboard bench over 8x8, 2x3 and 1x1 serializer instances.
module tb_serialize_3d_array;
  typedef struct {
    logic [3:0] d;
    int         r;
    int         c;
    logic       lc;
    logic       l;
  } beat_t;

  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n;
  int errors = 0, checks = 0;
  beat_t qa[$], qb[$], qc[$];

  logic a_iv, a_ir, a_ov, a_or, a_lc, a_l;
  logic [3:0] a_in [8][8];
  logic [3:0] a_od;
  logic [2:0] a_row, a_col;
  logic a_or_cmd = 1, bp_en = 0;
  logic [3:0] pat = 4'b1001;
  int ph = 0;

  logic b_iv, b_ir, b_ov, b_or, b_lc, b_l;
  logic [3:0] b_in [2][3];
  logic [3:0] b_od;
  logic [0:0] b_row;
  logic [1:0] b_col;

  logic c_iv, c_ir, c_ov, c_or, c_lc, c_l;
  logic [3:0] c_in [1][1];
  logic [3:0] c_od;
  logic [0:0] c_row, c_col;

  serialize_3d_array #(.BIT_WIDTH(4), .ROWS(8), .COLS(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in(a_in),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_row(a_row),
    .out_col(a_col), .out_last_col(a_lc), .out_last(a_l));
  serialize_3d_array #(.BIT_WIDTH(4), .ROWS(2), .COLS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in(b_in),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_row(b_row),
    .out_col(b_col), .out_last_col(b_lc), .out_last(b_l));
  serialize_3d_array #(.BIT_WIDTH(4), .ROWS(1), .COLS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in(c_in),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_row(c_row),
    .out_col(c_col), .out_last_col(c_lc), .out_last(c_l));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic cmp(input string p, input beat_t a, input beat_t e);
    chk({p, "_data"}, a.d, e.d);
    chk({p, "_row"}, a.r, e.r);
    chk({p, "_col"}, a.c, e.c);
    chk({p, "_last_col"}, a.lc, e.lc);
    chk({p, "_last"}, a.l, e.l);
  endtask

  // Every valid cycle is checked against the queue head, so a stall that alters outputs is caught too.
  always @(negedge clk)
    if (rst_n === 1'b1 && a_ov) begin
      if (qa.size() == 0) fail("a_unexpected_beat");
      else begin
        cmp("a", beat_t'{a_od, int'(a_row), int'(a_col), a_lc, a_l}, qa[0]);
        if (a_or) void'(qa.pop_front());
      end
    end

  always @(negedge clk)
    if (rst_n === 1'b1 && b_ov) begin
      if (qb.size() == 0) fail("b_unexpected_beat");
      else begin
        cmp("b", beat_t'{b_od, int'(b_row), int'(b_col), b_lc, b_l}, qb[0]);
        if (b_or) void'(qb.pop_front());
      end
    end

  always @(negedge clk)
    if (rst_n === 1'b1 && c_ov) begin
      if (qc.size() == 0) fail("c_unexpected_beat");
      else begin
        cmp("c", beat_t'{c_od, int'(c_row), int'(c_col), c_lc, c_l}, qc[0]);
        if (c_or) void'(qc.pop_front());
      end
    end

  initial begin
    a_or = 1;
    forever begin
      @(posedge clk);
      #1;
      a_or = bp_en ? pat[ph] : a_or_cmd;
      if (bp_en) ph = (ph + 1) % 4;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic fill8(input int k);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        logic [3:0] v;
        v = (k < 0) ? 4'((r*8 + c) % 16) : 4'(k);
        a_in[r][c] = v;
        qa.push_back(beat_t'{v, r, c, c == 7, r == 7 && c == 7});
      end
  endtask

  task automatic cap8(input int k);
    int n = 0;
    fill8(k);
    a_iv = 1;
    @(negedge clk);
    while (!a_ir && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) fail("a_capture_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a(input string name);
    int n = 0;
    while ((qa.size() != 0 || a_ov) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail({name, "_drain_timeout"});
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_left_in_queue"}, qa.size(), 0);
  endtask

  initial begin
    int n, k;
    rst_n = 0; a_iv = 0; b_iv = 0; c_iv = 0; b_or = 1; c_or = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_valid", a_ov, 0);
    chk("rst_a_row", a_row, 0);
    chk("rst_a_col", a_col, 0);
    chk("rst_a_last_col", a_lc, 0);
    chk("rst_a_last", a_l, 0);
    chk("rst_b_valid", b_ov, 0);
    chk("rst_c_last_col", c_lc, 1);
    chk("rst_c_last", c_l, 1);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rel_a_in_ready", a_ir, 1);
    chk("rel_b_in_ready", b_ir, 1);
    chk("rel_c_in_ready", c_ir, 1);
    // 2x3 single array, elements 1..6
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) begin
        b_in[r][c] = 4'(r*3 + c + 1);
        qb.push_back(beat_t'{4'(r*3 + c + 1), r, c, c == 2, r == 1 && c == 2});
      end
    b_iv = 1;
    @(posedge clk);
    #1 b_iv = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("t1_valid", b_ov, i <= 6);
      chk("t1_in_ready", b_ir, i >= 6);
    end
    chk("t1_left_in_queue", qb.size(), 0);
    // Backpressure 1,0,0,1 on the 8x8 pattern
    @(posedge clk);
    #1;
    cap8(-1);
    a_iv = 0;
    bp_en = 1;
    drain_a("t2");
    bp_en = 0;
    repeat (2) @(posedge clk);
    #1;
    // Back-to-back A then B
    cap8(10);
    fill8(11);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("t3a_valid", a_ov, 1);
      chk("t3a_in_ready", a_ir, i == 63);
    end
    @(posedge clk);
    #1 a_iv = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("t3b_valid", a_ov, 1);
      chk("t3b_in_ready", a_ir, i == 63);
    end
    drain_a("t3");
    // Input isolation: all-F presented while streaming
    cap8(-1);
    fill8(15);
    n = 0;
    @(negedge clk);
    while (!a_ir && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("t4_capture_cycle", n, 63);
    @(posedge clk);
    #1 a_iv = 0;
    drain_a("t4");
    // Reset after beat 10
    cap8(-1);
    a_iv = 0;
    n = 0; k = 0;
    while (n < 11 && k < 300) begin
      @(negedge clk);
      k++;
      if (a_ov && a_or) n++;
    end
    if (k >= 300) fail("t5_count_timeout");
    @(posedge clk);
    #1 rst_n = 0;
    qa.delete();
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("t5_valid", a_ov, 0);
    chk("t5_row", a_row, 0);
    chk("t5_col", a_col, 0);
    chk("t5_in_ready", a_ir, 1);
    @(posedge clk);
    #1;
    cap8(-1);
    a_iv = 0;
    drain_a("t5");
    // Degenerate 1x1
    c_in[0][0] = 4'h7;
    qc.push_back(beat_t'{4'h7, 0, 0, 1'b1, 1'b1});
    c_iv = 1;
    @(posedge clk);
    #1 c_iv = 0;
    @(negedge clk);
    chk("t6_valid", c_ov, 1);
    @(negedge clk);
    chk("t6_done", c_ov, 0);
    chk("t6_left_in_queue", qc.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
